double_framebuffer: RTL and testbench

DOUBLE_FRAMEBUFFER -- requirements
Module: double_framebuffer

---
 rtl/framebuffer_pkg.sv | 20 ++
 rtl/fb_bank.sv | 30 +++
 rtl/double_framebuffer.sv | 168 ++++++++++++++++
 tb/tb_double_framebuffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_pkg.sv
// Shared definitions for the double framebuffer: clear FSM state encoding
// and a small address range helper used on the write path.
package framebuffer_pkg;

  // Clear engine states: IDLE accepts pixel writes, CLEAR owns the back bank.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_e;

  // Number of display banks; front and back.
  localparam int NUM_BANKS = 2;

  // True when a write address falls inside the frame. Done in 32-bit
  // arithmetic so a power-of-two frame size does not wrap to zero.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned size);
    return addr < size;
  endfunction

endpackage

// File: rtl/fb_bank.sv
// One framebuffer bank: simple dual-port block RAM with a single write port
// and a registered read port. Contents are intentionally not reset.
module fb_bank #(
  parameter int DEPTH      = 76800,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: the caller guarantees waddr is in range whenever we is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port giving one cycle of read latency.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/double_framebuffer.sv
// Double-buffered framebuffer: the display reads the front bank while the
// renderer writes (or bulk-clears) the back bank; a swap exchanges them.
// Optional macro FB_SWAP_VSYNC_EN: when defined, a pending swap waits for a
// frame_start pulse so the exchange lines up with the display frame boundary.
// Without it, frame_start is ignored and a swap happens as soon as allowed.
module double_framebuffer
  import framebuffer_pkg::*;
#(
  parameter  int FB_WIDTH   = 320,
  parameter  int FB_HEIGHT  = 240,
  parameter  int DATA_WIDTH = 12,
  localparam int FB_SIZE    = FB_WIDTH * FB_HEIGHT,
  localparam int ADDR_WIDTH = $clog2(FB_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  clear_busy,
  input  logic                  swap_req,
  input  logic                  frame_start,
  output logic                  front_sel
);

  clear_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_cnt_q, clear_cnt_d;
  logic [DATA_WIDTH-1:0] clear_val_q, clear_val_d;
  logic                  clear_last;

  logic                  front_sel_q;
  logic                  swap_pending_q;
  logic                  swap_want;
  logic                  swap_now;

  logic                  wr_fire;
  logic                  wr_in_range;
  logic                  bank_wr;
  logic [ADDR_WIDTH-1:0] bank_waddr;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [NUM_BANKS-1:0]  bank_we;
  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];

  logic                  rd_valid_q;
  logic                  rd_sel_q;

  assign clear_last  = (clear_cnt_q == ADDR_WIDTH'(FB_SIZE - 1));
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = addr_in_range(32'(wr_addr), FB_SIZE);
  assign front_sel   = front_sel_q;

  // Clear FSM state, sweep counter and latched fill value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      clear_cnt_q <= '0;
      clear_val_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      clear_val_q <= clear_val_d;
    end
  end

  // Next-state and outputs: a clear sweeps every address once, then returns to IDLE.
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    clear_val_d = clear_val_q;
    clear_busy  = 1'b0;
    wr_ready    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d     = CLEAR;
          clear_cnt_d = '0;
          clear_val_d = clear_value;
        end
      end
      CLEAR: begin
        clear_busy = 1'b1;
        wr_ready   = 1'b0;
        if (clear_last) begin
          state_d     = IDLE;
          clear_cnt_d = '0;
        end else begin
          clear_cnt_d = clear_cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign swap_want = swap_req | swap_pending_q;

`ifdef FB_SWAP_VSYNC_EN
  assign swap_now = swap_want & frame_start & ~clear_busy;
`else
  // frame_start has no role in this build; sink it so it reads as intentional.
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign swap_now = swap_want & ~clear_busy;
`endif

  // Bank selection and the single pending-swap flag that absorbs repeat requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      front_sel_q    <= front_sel_q ^ swap_now;
      swap_pending_q <= swap_want & ~swap_now;
    end
  end

  // Back-bank write mux: the clear sweep owns the port, otherwise in-range pixel writes.
  always_comb begin
    bank_wr    = 1'b0;
    bank_waddr = wr_addr;
    bank_wdata = wr_data;
    if (state_q == CLEAR) begin
      bank_wr    = 1'b1;
      bank_waddr = clear_cnt_q;
      bank_wdata = clear_val_q;
    end else if (wr_fire && wr_in_range) begin
      bank_wr = 1'b1;
    end
  end

  // Writes go to the bank that is not on display, using the pre-swap selection.
  assign bank_we = {bank_wr & ~front_sel_q, bank_wr & front_sel_q};

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    fb_bank #(
      .DEPTH      (FB_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .raddr (rd_addr),
      .rdata (bank_q[b])
    );
  end

  // Track which bank fed the read last cycle and hold rd_data at zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b1;
      rd_sel_q   <= front_sel_q;
    end
  end

  assign rd_data = rd_valid_q ? bank_q[rd_sel_q] : '0;

endmodule

// File: tb/tb_double_framebuffer.sv
// Self-checking bench for double_framebuffer on a small 6x4 frame. Read
// expectations come from a two-bank model and flow through a scoreboard queue.
// Works with or without FB_SWAP_VSYNC_EN defined.
module tb_double_framebuffer;

  localparam int W    = 6;
  localparam int H    = 4;
  localparam int DW   = 12;
  localparam int SIZE = W * H;
  localparam int AW   = $clog2(SIZE);

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          clear_start;
  logic [DW-1:0] clear_value;
  logic          clear_busy;
  logic          swap_req;
  logic          frame_start;
  logic          front_sel;

  logic [DW-1:0] model_mem [2][SIZE];
  logic          model_front;
  logic [DW-1:0] rd_queue [$];

  int vectors     = 0;
  int miscompares = 0;

  double_framebuffer #(
    .FB_WIDTH   (W),
    .FB_HEIGHT  (H),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .clear_busy  (clear_busy),
    .swap_req    (swap_req),
    .frame_start (frame_start),
    .front_sel   (front_sel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, let the edge take them, then drop the pulses.
  task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic cs, input logic [DW-1:0] cv,
                               input logic sr, input logic fs);
    wr_valid    = wv;
    wr_addr     = wa;
    wr_data     = wd;
    clear_start = cs;
    clear_value = cv;
    swap_req    = sr;
    frame_start = fs;
    tick();
    wr_valid    = 1'b0;
    clear_start = 1'b0;
    swap_req    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic fill_back(input logic [DW-1:0] value);
    for (int i = 0; i < SIZE; i++) model_mem[~model_front][i] = value;
  endtask

  task automatic read_pixel(input int addr);
    rd_addr = AW'(addr);
    rd_queue.push_back(model_mem[model_front][addr]);
    tick();
    checkOutput($sformatf("rd_data[%0d]", addr), 32'(rd_data), 32'(rd_queue.pop_front()));
  endtask

  task automatic do_swap(input string tag);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    model_front = ~model_front;
    checkOutput(tag, 32'(front_sel), 32'(model_front));
  endtask

  // Count cycles with clear_busy high, bounded so a stuck clear cannot hang the run.
  task automatic wait_clear(input string tag);
    int busy_cycles = 0;
    int ready_high  = 0;
    while (clear_busy && busy_cycles < 200) begin
      busy_cycles++;
      if (wr_ready) ready_high++;
      tick();
    end
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(SIZE));
    checkOutput({tag, "_wr_ready_high"}, 32'(ready_high), 32'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int cycles;
    int front_changes;
    logic [DW-1:0] pix;

    rstn        = 1'b0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    rd_addr     = '0;
    clear_start = 1'b0;
    clear_value = '0;
    swap_req    = 1'b0;
    frame_start = 1'b0;
    model_front = 1'b0;

    // Reset state while rstn is held low
    #12;
    checkOutput("rst_front_sel", 32'(front_sel), 32'(0));
    checkOutput("rst_clear_busy", 32'(clear_busy), 32'(0));
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'(1));
    checkOutput("rst_rd_data", 32'(rd_data), 32'(0));
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Clear bank 1 to zero, show it, check every address
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h000, 1'b0, 1'b0);
    fill_back(12'h000);
    checkOutput("clear_busy_rise", 32'(clear_busy), 32'(1));
    wait_clear("clear0");
    do_swap("swap_after_clear0");
    for (int i = 0; i < SIZE; i++) read_pixel(i);

    // Clear bank 0 to a pattern and show it
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h5A5, 1'b0, 1'b0);
    fill_back(12'h5A5);
    wait_clear("clear1");
    do_swap("swap_after_clear1");
    read_pixel(0);
    read_pixel(11);
    read_pixel(23);

    // Pixel writes to back bank 1, including an out-of-range address
    for (int k = 0; k < 5; k++) begin
      int a;
      case (k)
        0: begin a = 5;  pix = 12'hABC; end
        1: begin a = 0;  pix = DW'($urandom); end
        2: begin a = 17; pix = DW'($urandom); end
        3: begin a = 23; pix = DW'($urandom); end
        default: begin a = 25; pix = 12'hFFF; end
      endcase
      checkOutput("wr_ready_idle", 32'(wr_ready), 32'(1));
      applyStimulus(1'b1, AW'(a), pix, 1'b0, '0, 1'b0, 1'b0);
      if (a < SIZE) model_mem[~model_front][a] = pix;
    end
    do_swap("swap_after_writes");
    read_pixel(5);
    read_pixel(0);
    read_pixel(17);
    read_pixel(23);
    read_pixel(6);
    checkOutput("no_clear_from_write", 32'(clear_busy), 32'(0));

    // Three swap requests during a clear merge into one toggle after it ends
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h0F0, 1'b0, 1'b0);
    fill_back(12'h0F0);
    cycles = 0;
    front_changes = 0;
    while (clear_busy && cycles < 200) begin
      if (front_sel !== model_front) front_changes++;
      applyStimulus(1'b0, '0, '0, 1'b0, '0, (cycles == 3 || cycles == 6 || cycles == 9), 1'b0);
      cycles++;
    end
    checkOutput("midclear_busy_cycles", 32'(cycles), 32'(SIZE));
    checkOutput("midclear_front_changes", 32'(front_changes), 32'(0));
    checkOutput("front_hold_at_busy_fall", 32'(front_sel), 32'(model_front));
`ifdef FB_SWAP_VSYNC_EN
    repeat (5) tick();
    checkOutput("vsync_wait_frame_start", 32'(front_sel), 32'(model_front));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
`else
    tick();
`endif
    model_front = ~model_front;
    checkOutput("merged_swap_toggle", 32'(front_sel), 32'(model_front));
    repeat (4) tick();
    checkOutput("single_toggle_only", 32'(front_sel), 32'(model_front));
    read_pixel(0);
    read_pixel(23);

    // Swap and clear in the same cycle: swap first, clear hits the new back bank
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h777, 1'b1, 1'b1);
    model_front = ~model_front;
    fill_back(12'h777);
    checkOutput("swap_with_clear_front", 32'(front_sel), 32'(model_front));
    wait_clear("clear_after_swap");
    read_pixel(5);
    read_pixel(17);
    do_swap("swap_show_777");
    read_pixel(0);
    read_pixel(12);
    read_pixel(23);

    // A write coinciding with a swap lands in the pre-swap back bank
    applyStimulus(1'b1, AW'(3), 12'h321, 1'b0, '0, 1'b1, 1'b1);
    model_mem[~model_front][3] = 12'h321;
    model_front = ~model_front;
    checkOutput("swap_with_write_front", 32'(front_sel), 32'(model_front));
    read_pixel(3);
    read_pixel(5);

    // Reset halfway through a clear of bank 0
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h000, 1'b0, 1'b0);
    repeat (SIZE / 2) tick();
    for (int i = 0; i < SIZE / 2; i++) model_mem[~model_front][i] = 12'h000;
    rstn = 1'b0;
    #1;
    model_front = 1'b0;
    checkOutput("midreset_clear_busy", 32'(clear_busy), 32'(0));
    checkOutput("midreset_wr_ready", 32'(wr_ready), 32'(1));
    checkOutput("midreset_front_sel", 32'(front_sel), 32'(0));
    checkOutput("midreset_rd_data", 32'(rd_data), 32'(0));
    @(negedge clk);
    rstn = 1'b1;
    tick();
    read_pixel(0);
    read_pixel(11);
    read_pixel(12);
    read_pixel(23);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
